// File: rtl/spi_master_pkg.sv
// Peripheral constants for the SPI master: register offsets, CTRL bit
// positions, base-address decode and the shifter state encoding.
package spi_master_pkg;

  localparam logic [1:0] SPI_DATA  = 2'd0;
  localparam logic [1:0] SPI_CTRL  = 2'd1;
  localparam logic [1:0] SPI_DIV   = 2'd2;
  localparam logic [1:0] SPI_SPARE = 2'd3;

  localparam int unsigned CTRL_BUSY = 7;
  localparam int unsigned CTRL_DONE = 6;
  localparam int unsigned CTRL_SS   = 1;
  localparam int unsigned CTRL_IE   = 0;

  // $FE60-$FE63 sits in the same 32-byte page decode as timer/uart/rgb
  localparam logic [10:0] SPI_BASE_SEL = 11'b11111110011;

  function automatic logic spi_sel(input logic [15:0] a);
    return a[15:5] == SPI_BASE_SEL;
  endfunction

  typedef enum logic [1:0] {
    S_IDLE,
    S_LEAD,
    S_TRAIL
  } shift_state_t;

endpackage

// File: rtl/spi_master_if.sv
// CPU-side register bus of the SPI master peripheral.
interface spi_master_if;
  logic [7:0] dbr;
  logic [7:0] dbw;
  logic [1:0] addr;
  logic       we;

  modport master (input dbr, output dbw, output addr, output we);
  modport slave  (output dbr, input dbw, input addr, input we);
endinterface

// File: rtl/spi_master_shifter.sv
// Mode-0 MSB-first shift engine: half-period timer, bit counter, TX/RX
// shift registers and the MISO synchroniser.
module spi_master_shifter
  import spi_master_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] div,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic       busy,
  output logic       done_pulse,
  output logic [7:0] rx_byte,
  output logic       sck,
  output logic       mosi
);

  shift_state_t state;
  logic [7:0]   half_cnt;
  logic [7:0]   half_div;
  logic [7:0]   tx_sr;
  logic [7:0]   rx_sr;
  logic [2:0]   bit_cnt;
  logic         miso_q;
  logic         half_end;

  assign half_end   = (half_cnt == half_div);
  assign done_pulse = (state == S_TRAIL) && half_end && (bit_cnt == 3'd7);
  assign rx_byte    = rx_sr;
  assign mosi       = tx_sr[7];

  // miso_q is the first synchroniser stage; rx_sr acts as the second
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      half_cnt <= '0;
      half_div <= 8'd1;
      tx_sr    <= '0;
      rx_sr    <= '0;
      bit_cnt  <= '0;
      miso_q   <= 1'b0;
      sck      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      miso_q <= miso;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_LEAD;
            half_cnt <= '0;
            half_div <= (div == 8'd0) ? 8'd1 : div;
            tx_sr    <= tx_byte;
            bit_cnt  <= '0;
            sck      <= 1'b0;
            busy     <= 1'b1;
          end
        end
        S_LEAD: begin
          if (half_end) begin
            state    <= S_TRAIL;
            half_cnt <= '0;
            sck      <= 1'b1;
            rx_sr    <= {rx_sr[6:0], miso_q};
          end else begin
            half_cnt <= half_cnt + 8'd1;
          end
        end
        S_TRAIL: begin
          if (half_end) begin
            half_cnt <= '0;
            sck      <= 1'b0;
            tx_sr    <= {tx_sr[6:0], 1'b0};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              state <= S_LEAD;
            end
          end else begin
            half_cnt <= half_cnt + 8'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          sck   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/spi_master.sv
// Memory-mapped SPI master at $FE60-$FE63: register file, read mux,
// completion interrupt, and the shift engine.
module spi_master
  import spi_master_pkg::*;
#(
  parameter logic [7:0] DIV_RST = 8'd3
) (
  input  logic         clk,
  input  logic         rst,
  spi_master_if.slave  bus,
  output logic         sck,
  output logic         mosi,
  input  logic         miso,
  output logic         ss_n,
  output logic         irq
);

  logic [7:0] data_rx;
  logic [7:0] div_r;
  logic       ie;
  logic       done;
  logic       ss;
  logic       busy;
  logic       done_pulse;
  logic [7:0] rx_byte;
  logic       start;
  logic       wr_ctrl;

  assign start   = bus.we && (bus.addr == SPI_DATA) && !busy;
  assign wr_ctrl = bus.we && (bus.addr == SPI_CTRL);
  assign ss_n    = ~ss;

  spi_master_shifter u_shifter (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .div        (div_r),
    .tx_byte    (bus.dbw),
    .miso       (miso),
    .busy       (busy),
    .done_pulse (done_pulse),
    .rx_byte    (rx_byte),
    .sck        (sck),
    .mosi       (mosi)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_rx <= '0;
      div_r   <= DIV_RST;
      ie      <= 1'b0;
      done    <= 1'b0;
      ss      <= 1'b0;
      irq     <= 1'b0;
      bus.dbr <= '0;
    end else begin
      case (bus.addr)
        SPI_DATA: bus.dbr <= data_rx;
        SPI_CTRL: bus.dbr <= {busy, done, 4'b0000, ss, ie};
        SPI_DIV:  bus.dbr <= div_r;
        default:  bus.dbr <= '1;
      endcase

      if (wr_ctrl) begin
        ss <= bus.dbw[CTRL_SS];
        ie <= bus.dbw[CTRL_IE];
      end
      if (bus.we && (bus.addr == SPI_DIV))
        div_r <= bus.dbw;

      // completion takes priority over a coincident software clear
      if (done_pulse)
        done <= 1'b1;
      else if (start)
        done <= 1'b0;
      else if (wr_ctrl && bus.dbw[CTRL_DONE])
        done <= 1'b0;

      if (done_pulse)
        data_rx <= rx_byte;

      irq <= done & ie;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: register table, loopback and slave
// transfers, interrupt, busy-write and mid-transfer reset sequences.
module tb_spi_master;
  import spi_master_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sck, mosi, miso, ss_n, irq;
  logic loopback = 1'b0;
  logic load = 1'b0;
  logic [7:0] slave_byte = 8'h00;
  logic [7:0] slave_sr;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic g_irq_busy, g_irq_end;

  typedef struct {
    logic [7:0]  rx;
    int unsigned len;
  } xfer_t;
  xfer_t xfer_q[$];
  logic [7:0] rd_q[$];

  typedef struct {
    logic       wr;
    logic [1:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[13];

  spi_master_if bus ();

  spi_master #(.DIV_RST(8'd3)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .sck  (sck),
    .mosi (mosi),
    .miso (miso),
    .ss_n (ss_n),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  // mode-0 slave: presents MSB on load, shifts on each falling sck
  always @(negedge sck or posedge load) begin
    if (load) slave_sr <= slave_byte;
    else      slave_sr <= {slave_sr[6:0], 1'b0};
  end
  assign miso = loopback ? mosi : slave_sr[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    bus.we = 1'b1; bus.addr = a; bus.dbw = d;
    @(posedge clk); #1;
    bus.we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(posedge clk); #1;
    bus.addr = a;
    @(posedge clk); #1;
    d = bus.dbr;
  endtask

  task automatic read_check(input string name, input logic [1:0] a, input logic [7:0] exp);
    logic [7:0] got;
    rd_q.push_back(exp);
    bus_read(a, got);
    check(name, {24'h0, got}, {24'h0, rd_q.pop_front()});
  endtask

  task automatic run_xfer(input string tag, input logic [7:0] tx, input logic lb,
                          input logic [7:0] sbyte, input int unsigned len_exp,
                          input int unsigned half_exp, input int unsigned inj_at,
                          input logic [1:0] inj_addr, input logic [7:0] inj_data);
    xfer_t e;
    int unsigned busy_n, rises, w, wmin, wmax, it;
    logic [7:0] got_tx, got_rx;
    logic prev_sck, skip, restore, finished;
    busy_n = 0; rises = 0; w = 0; wmin = 999; wmax = 0;
    got_tx = '0; prev_sck = 1'b0; skip = 1'b0; restore = 1'b0; finished = 1'b0;
    g_irq_busy = 1'bx; g_irq_end = 1'bx;
    loopback = lb; slave_byte = sbyte;
    load = 1'b1; #1 load = 1'b0;
    e.rx = lb ? tx : sbyte;
    e.len = len_exp;
    xfer_q.push_back(e);
    bus_write(SPI_DATA, tx);
    bus.addr = SPI_CTRL;
    @(negedge clk);
    for (it = 0; it < 400; it++) begin
      @(negedge clk);
      if (sck && !prev_sck) begin
        rises++;
        got_tx = {got_tx[6:0], mosi};
        w = 0;
      end
      if (sck) w++;
      if (!sck && prev_sck) begin
        if (w < wmin) wmin = w;
        if (w > wmax) wmax = w;
      end
      prev_sck = sck;
      if (skip) begin
        busy_n++;
        skip = 1'b0;
      end else if (bus.dbr[CTRL_BUSY]) begin
        busy_n++;
      end else if (busy_n > 0) begin
        g_irq_end = irq;
        finished = 1'b1;
        break;
      end
      g_irq_busy = irq;
      if (restore) begin
        bus.we = 1'b0; bus.addr = SPI_CTRL; restore = 1'b0;
      end
      if (it == inj_at) begin
        bus.we = 1'b1; bus.addr = inj_addr; bus.dbw = inj_data;
        skip = 1'b1; restore = 1'b1;
      end
    end
    bus.we = 1'b0;
    check({tag, "_finished"}, {31'h0, finished}, 32'h1);
    e = xfer_q.pop_front();
    check({tag, "_len"}, busy_n, e.len);
    check({tag, "_rises"}, rises, 32'd8);
    check({tag, "_sck_hi_min"}, wmin, half_exp);
    check({tag, "_sck_hi_max"}, wmax, half_exp);
    check({tag, "_mosi_bits"}, {24'h0, got_tx}, {24'h0, tx});
    bus_read(SPI_DATA, got_rx);
    check({tag, "_rx"}, {24'h0, got_rx}, {24'h0, e.rx});
  endtask

  initial begin
    logic [7:0] got;
    int unsigned rises;
    logic prev_sck;

    bus.we = 1'b0; bus.addr = 2'd0; bus.dbw = 8'h00;
    vecs[0]  = '{1'b0, SPI_DATA,  8'h00, 8'h00};
    vecs[1]  = '{1'b0, SPI_CTRL,  8'h00, 8'h00};
    vecs[2]  = '{1'b0, SPI_DIV,   8'h00, 8'h03};
    vecs[3]  = '{1'b0, SPI_SPARE, 8'h00, 8'hFF};
    vecs[4]  = '{1'b1, SPI_DIV,   8'h5A, 8'h00};
    vecs[5]  = '{1'b0, SPI_DIV,   8'h00, 8'h5A};
    vecs[6]  = '{1'b1, SPI_CTRL,  8'hFF, 8'h00};
    vecs[7]  = '{1'b0, SPI_CTRL,  8'h00, 8'h03};
    vecs[8]  = '{1'b1, SPI_CTRL,  8'h00, 8'h00};
    vecs[9]  = '{1'b0, SPI_CTRL,  8'h00, 8'h00};
    vecs[10] = '{1'b1, SPI_SPARE, 8'h55, 8'h00};
    vecs[11] = '{1'b0, SPI_SPARE, 8'h00, 8'hFF};
    vecs[12] = '{1'b0, SPI_DIV,   8'h00, 8'h5A};

    load = 1'b1; #1 load = 1'b0;
    #2;
    check("rst_sck", {31'h0, sck}, 32'h0);
    check("rst_ss_n", {31'h0, ss_n}, 32'h1);
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_dbr", {24'h0, bus.dbr}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      if (vecs[i].wr) bus_write(vecs[i].a, vecs[i].d);
      else read_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].exp);
    end

    // loopback, DIV=1
    bus_write(SPI_DIV, 8'd1);
    bus_write(SPI_CTRL, 8'h02);
    check("lb_ss_n", {31'h0, ss_n}, 32'h0);
    run_xfer("lb_a5", 8'hA5, 1'b1, 8'h00, 32, 2, 999, SPI_DATA, 8'h00);
    read_check("lb_ctrl", SPI_CTRL, 8'h42);

    // slave returns 3C, DIV=0 clamped and DIV=7
    bus_write(SPI_DIV, 8'd0);
    run_xfer("sl_d0", 8'h81, 1'b0, 8'h3C, 32, 2, 999, SPI_DATA, 8'h00);
    bus_write(SPI_DIV, 8'd7);
    run_xfer("sl_d7", 8'h7E, 1'b0, 8'h3C, 128, 8, 999, SPI_DATA, 8'h00);

    // interrupt rises one cycle after DONE, clears after DONE write-1
    bus_write(SPI_DIV, 8'd1);
    bus_write(SPI_CTRL, 8'h03);
    run_xfer("ie", 8'h5C, 1'b1, 8'h00, 32, 2, 999, SPI_DATA, 8'h00);
    check("irq_during_busy", {31'h0, g_irq_busy}, 32'h0);
    check("irq_after_done", {31'h0, g_irq_end}, 32'h1);
    read_check("ie_ctrl", SPI_CTRL, 8'h43);
    bus_write(SPI_CTRL, 8'h41);
    @(posedge clk); #1;
    check("irq_cleared", {31'h0, irq}, 32'h0);
    read_check("ie_ctrl_after", SPI_CTRL, 8'h01);

    // writes while busy: DATA ignored, DIV updates without retiming
    bus_write(SPI_CTRL, 8'h02);
    run_xfer("busy_data", 8'hF0, 1'b1, 8'h00, 32, 2, 6, SPI_DATA, 8'h11);
    run_xfer("busy_div", 8'h96, 1'b1, 8'h00, 32, 2, 10, SPI_DIV, 8'h07);
    read_check("busy_div_reg", SPI_DIV, 8'h07);

    // reset asserted mid-transfer after the 4th sck rise
    bus_write(SPI_DIV, 8'd1);
    loopback = 1'b1;
    bus_write(SPI_DATA, 8'hC3);
    rises = 0; prev_sck = 1'b0;
    for (int k = 0; k < 200 && rises < 4; k++) begin
      @(negedge clk);
      if (sck && !prev_sck) rises++;
      prev_sck = sck;
    end
    check("mid_rises", rises, 32'd4);
    check("mid_pre_sck", {31'h0, sck}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("mid_sck", {31'h0, sck}, 32'h0);
    check("mid_ss_n", {31'h0, ss_n}, 32'h1);
    check("mid_irq", {31'h0, irq}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    read_check("mid_ctrl", SPI_CTRL, 8'h00);
    read_check("mid_data", SPI_DATA, 8'h00);
    read_check("mid_div", SPI_DIV, 8'h03);
    bus_write(SPI_DIV, 8'd1);
    bus_write(SPI_CTRL, 8'h02);
    run_xfer("post_rst", 8'h3C, 1'b1, 8'h00, 32, 2, 999, SPI_DATA, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
